// File: rtl/edge_event_arbiter_if.sv
// edge_event_arbiter_if: event, configuration, handshake and status bundle
// for edge_event_arbiter. The slave modport belongs to the arbiter. The master
// modport belongs to the block that drives the event lines and consumes grants.
interface edge_event_arbiter_if #(
    parameter int unsigned P_width = 4
);
    localparam int unsigned P_index_w = $clog2(P_width);

    // Event lines and per-line configuration
    logic [P_width-1:0]   I_signal;
    logic [P_width-1:0]   I_edge_sel;
    logic [P_width-1:0]   I_enable;

    // Consumer handshake and status control
    logic                 I_ack;
    logic                 I_clear_ovf;

    // Grant and status outputs
    logic                 O_valid;
    logic [P_index_w-1:0] O_index;
    logic [P_width-1:0]   O_pending;
    logic [P_width-1:0]   O_overflow;

    modport slave (
        input  I_signal,
        input  I_edge_sel,
        input  I_enable,
        input  I_ack,
        input  I_clear_ovf,
        output O_valid,
        output O_index,
        output O_pending,
        output O_overflow
    );

    modport master (
        output I_signal,
        output I_edge_sel,
        output I_enable,
        output I_ack,
        output I_clear_ovf,
        input  O_valid,
        input  O_index,
        input  O_pending,
        input  O_overflow
    );
endinterface

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: detects a selectable edge on each event line and latches
// it as a pending request. Pending lines are granted one at a time through a
// valid/ack handshake. There is always one IDLE bubble cycle between grants.
// Optional feature: define EDGE_EVENT_ARB_ROUND_ROBIN_EN for round-robin
// selection. Without it, the lowest set pending index wins.
module edge_event_arbiter #(
    parameter int unsigned P_width = 4
) (
    input  logic                 I_clock,
    input  logic                 I_reset,
    edge_event_arbiter_if.slave  bus
);
    localparam int unsigned P_index_w = $clog2(P_width);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [P_width-1:0]   last_q;
    logic [P_width-1:0]   pending_q, pending_d;
    logic [P_width-1:0]   overflow_q, overflow_d;
    logic [P_index_w-1:0] index_q, index_d;

    logic [P_width-1:0]   rise, fall, hit, set_req, ack_clr, ovf_evt;
    logic                 ack_fire;
    logic                 winner_found;
    logic [P_index_w-1:0] winner_idx;

    // Edge detection against the previous sample, polarity chosen per line
    always_comb begin
        rise    = ~last_q & bus.I_signal;
        fall    = last_q & ~bus.I_signal;
        hit     = (bus.I_edge_sel & fall) | (~bus.I_edge_sel & rise);
        set_req = hit & bus.I_enable;
    end

    // Ack retires only the granted line, and only while in GRANT
    always_comb begin
        ack_fire = (state_q == S_GRANT) && bus.I_ack;
        ack_clr  = '0;
        if (ack_fire) begin
            ack_clr[index_q] = 1'b1;
        end
    end

    // A new request lands on a line that is still pending. If the same line
    // is acked in that cycle, the request counts as a fresh one, not an overflow.
    always_comb begin
        ovf_evt    = set_req & pending_q & ~ack_clr;
        pending_d  = (pending_q & ~ack_clr) | set_req;
        overflow_d = (bus.I_clear_ovf ? '0 : overflow_q) | ovf_evt;
    end

`ifdef EDGE_EVENT_ARB_ROUND_ROBIN_EN
    logic [P_index_w-1:0] rr_ptr_q, rr_ptr_d;
    int unsigned          rr_cand;

    // Round-robin search starts just after the last acked index and wraps.
    // The last acked index is checked last, so it has the lowest priority.
    always_comb begin
        winner_found = 1'b0;
        winner_idx   = '0;
        rr_cand      = 0;
        for (int unsigned k = 1; k <= P_width; k++) begin
            rr_cand = (32'(rr_ptr_q) + k) % P_width;
            if (!winner_found && pending_q[rr_cand]) begin
                winner_found = 1'b1;
                winner_idx   = P_index_w'(rr_cand);
            end
        end
    end

    // The pointer moves to the granted index each time a grant is acked
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (ack_fire) begin
            rr_ptr_d = index_q;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority: the lowest set pending index wins
    always_comb begin
        winner_found = 1'b0;
        winner_idx   = '0;
        for (int unsigned i = 0; i < P_width; i++) begin
            if (!winner_found && pending_q[i]) begin
                winner_found = 1'b1;
                winner_idx   = P_index_w'(i);
            end
        end
    end
`endif

    // Next state and grant index. IDLE uses only the registered pending value.
    // The index is frozen for the whole of GRANT.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        unique case (state_q)
            S_IDLE: begin
                if (pending_q != '0) begin
                    state_d = S_GRANT;
                    index_d = winner_idx;
                end
            end
            S_GRANT: begin
                if (bus.I_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register plus the edge, pending and overflow registers.
    // Reset takes priority over every other input.
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            last_q     <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            last_q     <= bus.I_signal;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Outputs decoded from the state and registers
    always_comb begin
        bus.O_valid    = (state_q == S_GRANT);
        bus.O_index    = index_q;
        bus.O_pending  = pending_q;
        bus.O_overflow = overflow_q;
    end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed tests for edge_event_arbiter with P_width=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_edge_event_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    edge_event_arbiter_if #(.P_width(4)) bus ();

    edge_event_arbiter #(.P_width(4)) dut (
        .I_clock (clk),
        .I_reset (rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.I_signal    = '0;
        bus.I_ack       = 1'b0;
        bus.I_clear_ovf = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (bus.O_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b exp 0", bus.O_valid);
        end
        checks++;
        if (bus.O_index !== 2'd0) begin
            errors++;
            $display("FAIL reset_index got %0d exp 0", bus.O_index);
        end
        checks++;
        if (bus.O_pending !== 4'b0000 || bus.O_overflow !== 4'b0000) begin
            errors++;
            $display("FAIL reset_regs got pend=%b ovf=%b exp 0000/0000",
                     bus.O_pending, bus.O_overflow);
        end
    endtask

    task automatic test_basic;
        bus.I_signal = 4'b0001;
        tick();
        checks++;
        if (bus.O_pending !== 4'b0001 || bus.O_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pend got pend=%b valid=%b exp 0001/0",
                     bus.O_pending, bus.O_valid);
        end
        tick();
        checks++;
        if (bus.O_valid !== 1'b1 || bus.O_index !== 2'd0) begin
            errors++;
            $display("FAIL basic_grant got valid=%b idx=%0d exp 1/0",
                     bus.O_valid, bus.O_index);
        end
        bus.I_ack = 1'b1;
        tick();
        bus.I_ack = 1'b0;
        checks++;
        if (bus.O_pending !== 4'b0000 || bus.O_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack got pend=%b valid=%b exp 0000/0",
                     bus.O_pending, bus.O_valid);
        end
        // A falling edge on a rising-edge line must not set pending
        bus.I_signal = 4'b0000;
        tick();
        checks++;
        if (bus.O_pending !== 4'b0000) begin
            errors++;
            $display("FAIL basic_fall_ignored got %b exp 0000", bus.O_pending);
        end
    endtask

    task automatic test_enable;
        bus.I_enable = 4'b1110;
        bus.I_signal = 4'b0001;
        tick();
        checks++;
        if (bus.O_pending !== 4'b0000) begin
            errors++;
            $display("FAIL enable_gate got %b exp 0000", bus.O_pending);
        end
        bus.I_signal = 4'b0000;
        bus.I_enable = 4'b1111;
        tick();
    endtask

    task automatic test_falling;
        bus.I_edge_sel = 4'b0010;
        bus.I_signal   = 4'b0010;
        tick();
        checks++;
        if (bus.O_pending !== 4'b0000) begin
            errors++;
            $display("FAIL fall_rise_ignored got %b exp 0000", bus.O_pending);
        end
        bus.I_signal = 4'b0000;
        tick();
        checks++;
        if (bus.O_pending !== 4'b0010) begin
            errors++;
            $display("FAIL fall_set got %b exp 0010", bus.O_pending);
        end
        tick();
        checks++;
        if (bus.O_valid !== 1'b1 || bus.O_index !== 2'd1) begin
            errors++;
            $display("FAIL fall_grant got valid=%b idx=%0d exp 1/1",
                     bus.O_valid, bus.O_index);
        end
        bus.I_ack = 1'b1;
        tick();
        bus.I_ack = 1'b0;
        bus.I_edge_sel = 4'b0000;
        checks++;
        if (bus.O_pending !== 4'b0000 || bus.O_valid !== 1'b0) begin
            errors++;
            $display("FAIL fall_ack got pend=%b valid=%b exp 0000/0",
                     bus.O_pending, bus.O_valid);
        end
    endtask

    // Lines 1 and 3 rise together. Line 1 re-fires in its own ack cycle, so
    // pending stays 1010. Fixed priority then gives 1,3. Round-robin gives 3,1.
    task automatic test_priority;
        logic [1:0] exp_a;
        logic [1:0] exp_b;
        logic [3:0] exp_mid;
`ifdef EDGE_EVENT_ARB_ROUND_ROBIN_EN
        exp_a   = 2'd3;
        exp_b   = 2'd1;
        exp_mid = 4'b0010;
`else
        exp_a   = 2'd1;
        exp_b   = 2'd3;
        exp_mid = 4'b1000;
`endif
        do_reset();
        bus.I_signal = 4'b1010;
        tick();
        checks++;
        if (bus.O_pending !== 4'b1010) begin
            errors++;
            $display("FAIL prio_pend got %b exp 1010", bus.O_pending);
        end
        tick();
        checks++;
        if (bus.O_valid !== 1'b1 || bus.O_index !== 2'd1) begin
            errors++;
            $display("FAIL prio_first got valid=%b idx=%0d exp 1/1",
                     bus.O_valid, bus.O_index);
        end
        bus.I_signal = 4'b1000;
        tick();
        bus.I_signal = 4'b1010;
        bus.I_ack    = 1'b1;
        tick();
        bus.I_ack = 1'b0;
        checks++;
        if (bus.O_pending !== 4'b1010 || bus.O_overflow !== 4'b0000 || bus.O_valid !== 1'b0) begin
            errors++;
            $display("FAIL prio_rehit got pend=%b ovf=%b valid=%b exp 1010/0000/0",
                     bus.O_pending, bus.O_overflow, bus.O_valid);
        end
        tick();
        checks++;
        if (bus.O_valid !== 1'b1 || bus.O_index !== exp_a) begin
            errors++;
            $display("FAIL prio_second got valid=%b idx=%0d exp 1/%0d",
                     bus.O_valid, bus.O_index, exp_a);
        end
        bus.I_ack = 1'b1;
        tick();
        bus.I_ack = 1'b0;
        checks++;
        if (bus.O_pending !== exp_mid || bus.O_valid !== 1'b0) begin
            errors++;
            $display("FAIL prio_mid got pend=%b valid=%b exp %b/0",
                     bus.O_pending, bus.O_valid, exp_mid);
        end
        tick();
        checks++;
        if (bus.O_valid !== 1'b1 || bus.O_index !== exp_b) begin
            errors++;
            $display("FAIL prio_third got valid=%b idx=%0d exp 1/%0d",
                     bus.O_valid, bus.O_index, exp_b);
        end
        bus.I_ack = 1'b1;
        tick();
        bus.I_ack    = 1'b0;
        bus.I_signal = 4'b0000;
        checks++;
        if (bus.O_pending !== 4'b0000 || bus.O_valid !== 1'b0) begin
            errors++;
            $display("FAIL prio_done got pend=%b valid=%b exp 0000/0",
                     bus.O_pending, bus.O_valid);
        end
        tick();
    endtask

    task automatic test_overflow;
        bus.I_signal = 4'b0100;
        tick();
        bus.I_signal = 4'b0000;
        tick();
        bus.I_signal = 4'b0100;
        tick();
        checks++;
        if (bus.O_overflow !== 4'b0100 || bus.O_pending !== 4'b0100) begin
            errors++;
            $display("FAIL ovf_set got ovf=%b pend=%b exp 0100/0100",
                     bus.O_overflow, bus.O_pending);
        end
        checks++;
        if (bus.O_valid !== 1'b1 || bus.O_index !== 2'd2) begin
            errors++;
            $display("FAIL ovf_grant got valid=%b idx=%0d exp 1/2",
                     bus.O_valid, bus.O_index);
        end
        bus.I_ack = 1'b1;
        tick();
        bus.I_ack = 1'b0;
        tick();
        checks++;
        if (bus.O_overflow !== 4'b0100 || bus.O_pending !== 4'b0000) begin
            errors++;
            $display("FAIL ovf_sticky got ovf=%b pend=%b exp 0100/0000",
                     bus.O_overflow, bus.O_pending);
        end
        bus.I_clear_ovf = 1'b1;
        tick();
        bus.I_clear_ovf = 1'b0;
        bus.I_signal    = 4'b0000;
        checks++;
        if (bus.O_overflow !== 4'b0000) begin
            errors++;
            $display("FAIL ovf_clear got %b exp 0000", bus.O_overflow);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        bus.I_signal = 4'b0001;
        tick();
        tick();
        bus.I_signal = 4'b0000;
        tick();
        bus.I_signal = 4'b0001;
        bus.I_ack    = 1'b1;
        tick();
        bus.I_ack = 1'b0;
        checks++;
        if (bus.O_pending !== 4'b0001 || bus.O_overflow !== 4'b0000 || bus.O_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_bubble got pend=%b ovf=%b valid=%b exp 0001/0000/0",
                     bus.O_pending, bus.O_overflow, bus.O_valid);
        end
        tick();
        checks++;
        if (bus.O_valid !== 1'b1 || bus.O_index !== 2'd0) begin
            errors++;
            $display("FAIL b2b_regrant got valid=%b idx=%0d exp 1/0",
                     bus.O_valid, bus.O_index);
        end
        bus.I_ack = 1'b1;
        tick();
        bus.I_ack    = 1'b0;
        bus.I_signal = 4'b0000;
        checks++;
        if (bus.O_pending !== 4'b0000 || bus.O_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done got pend=%b valid=%b exp 0000/0",
                     bus.O_pending, bus.O_valid);
        end
        tick();
    endtask

    task automatic test_reset_in_grant;
        bus.I_signal = 4'b0100;
        tick();
        bus.I_signal = 4'b0000;
        tick();
        bus.I_signal = 4'b0100;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.O_valid !== 1'b0 || bus.O_pending !== 4'b0000 ||
            bus.O_overflow !== 4'b0000 || bus.O_index !== 2'd0) begin
            errors++;
            $display("FAIL rstg_clear got valid=%b pend=%b ovf=%b idx=%0d exp 0/0000/0000/0",
                     bus.O_valid, bus.O_pending, bus.O_overflow, bus.O_index);
        end
        tick();
        checks++;
        if (bus.O_pending !== 4'b0100 || bus.O_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstg_held_high got pend=%b valid=%b exp 0100/0",
                     bus.O_pending, bus.O_valid);
        end
        tick();
        checks++;
        if (bus.O_valid !== 1'b1 || bus.O_index !== 2'd2) begin
            errors++;
            $display("FAIL rstg_grant got valid=%b idx=%0d exp 1/2",
                     bus.O_valid, bus.O_index);
        end
        bus.I_ack = 1'b1;
        tick();
        bus.I_ack    = 1'b0;
        bus.I_signal = 4'b0000;
        tick();
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.I_signal    = '0;
        bus.I_edge_sel  = '0;
        bus.I_enable    = 4'b1111;
        bus.I_ack       = 1'b0;
        bus.I_clear_ovf = 1'b0;

        test_reset();
        test_basic();
        test_enable();
        test_falling();
        test_priority();
        test_overflow();
        test_back_to_back();
        test_reset_in_grant();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
